// File: rtl/i2c_cmd_seq.sv
// i2c_cmd_seq
//   Command sequencer in front of the 1 MHz I2C master, CLK40 domain.
//   Accepts one transaction descriptor and its write payload from the host.
//   It then loads the master (byte count, address, payload) and raises EXECUTE.
//   It waits for the master's READY handshake and reports DONE/NACK/TIMEOUT/ERR.
//
//   Optional build macro: I2C_RBK_CHECK_EN
//     When defined, a read whose readback byte count differs from NBYTES
//     pulses ERR together with DONE.
//
// Ports
//   CLK40, RST_N                 clock, asynchronous active-low reset
//   CMD_VALID/CMD_READY          descriptor handshake (CMD_RD, CMD_NBYTES, CMD_ADDR)
//   DIN_VALID/DIN_READY/DIN      write payload handshake
//   I2C_READY, I2C_S_NACK        master status, 1 MHz domain (synchronised here)
//   I2C_RBK_WE                   master readback strobe, CLK40-timed
//   DEV_SEL, LOAD_N_BYTE, LOAD_ADDR, WRT_ENA, WRT_ADDR, WRT_DATA, EXECUTE
//                                master control strobes and data bus
//   DONE, NACK, TIMEOUT, ERR, RBK_CNT, BUSY
//                                status to the host
module i2c_cmd_seq #(
  parameter int TO_CYCLES = 2000000,
  parameter int START_TO  = 400
) (
  input  logic       CLK40,
  input  logic       RST_N,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic       CMD_RD,
  input  logic [3:0] CMD_NBYTES,
  input  logic [7:0] CMD_ADDR,
  input  logic       DIN_VALID,
  output logic       DIN_READY,
  input  logic [7:0] DIN,
  input  logic       I2C_READY,
  input  logic       I2C_RBK_WE,
  input  logic       I2C_S_NACK,
  output logic       DEV_SEL,
  output logic       LOAD_N_BYTE,
  output logic       LOAD_ADDR,
  output logic       WRT_ENA,
  output logic [3:0] WRT_ADDR,
  output logic [7:0] WRT_DATA,
  output logic       EXECUTE,
  output logic       DONE,
  output logic       NACK,
  output logic       TIMEOUT,
  output logic       ERR,
  output logic [3:0] RBK_CNT,
  output logic       BUSY
);

  localparam int TMR_W = $clog2(TO_CYCLES + 1);
  localparam logic [TMR_W-1:0] TO_LAST    = TMR_W'(TO_CYCLES - 1);
  localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_NB, S_LD_ADR, S_LD_DATA, S_EXEC, S_WAIT_DONE, S_FINISH
  } state_t;

  state_t state_q, state_d;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // ---- 1 MHz domain status synchronisers
  logic [1:0] rdy_sync, nack_sync;
  logic       rdy_s, nack_s;

  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      rdy_sync  <= 2'b00;
      nack_sync <= 2'b00;
    end else begin
      rdy_sync  <= {rdy_sync[0], I2C_READY};
      nack_sync <= {nack_sync[0], I2C_S_NACK};
    end
  end

  assign rdy_s  = rdy_sync[1];
  assign nack_s = nack_sync[1];

  // ---- descriptor latch (data only, no reset)
  logic       cmd_acc;
  logic [3:0] nbytes_q;
  logic       rd_q;
  logic [7:0] addr_q;

  always_ff @(posedge CLK40) begin
    if (cmd_acc) begin
      nbytes_q <= CMD_NBYTES;
      rd_q     <= CMD_RD;
      addr_q   <= CMD_ADDR;
    end
  end

  // ---- next-state and next-output logic
  logic [TMR_W-1:0] timer_q;
  logic [3:0]       idx_q, idx_d;
  logic             wrt_ena_d, err_d, nack_d, timeout_d;
  logic [3:0]       wrt_addr_d, rbk_d;
  logic [7:0]       wrt_data_d;

  always_comb begin
    state_d    = state_q;
    cmd_acc    = 1'b0;
    idx_d      = idx_q;
    wrt_ena_d  = 1'b0;
    wrt_addr_d = WRT_ADDR;
    wrt_data_d = WRT_DATA;
    err_d      = 1'b0;
    nack_d     = NACK;
    timeout_d  = TIMEOUT;
    rbk_d      = RBK_CNT;
    case (state_q)
      S_IDLE: begin
        if (CMD_VALID) begin
          if (CMD_NBYTES == 4'd0) begin
            err_d = 1'b1;
          end else begin
            cmd_acc    = 1'b1;
            nack_d     = 1'b0;
            timeout_d  = 1'b0;
            rbk_d      = 4'd0;
            wrt_data_d = {CMD_NBYTES, CMD_RD, 3'b000};
            state_d    = S_LD_NB;
          end
        end
      end
      S_LD_NB: begin
        wrt_data_d = addr_q;
        state_d    = S_LD_ADR;
      end
      S_LD_ADR: begin
        idx_d   = 4'd0;
        state_d = rd_q ? S_EXEC : S_LD_DATA;
      end
      S_LD_DATA: begin
        // DIN_READY is held high for the whole phase, so DIN_VALID alone
        // completes the handshake.
        if (DIN_VALID) begin
          wrt_ena_d  = 1'b1;
          wrt_addr_d = idx_q;
          wrt_data_d = DIN;
          idx_d      = idx_q + 4'd1;
          if (idx_q == nbytes_q - 4'd1)
            state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!rdy_s) begin
          state_d = S_WAIT_DONE;
        end else if (timer_q == START_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end
      end
      S_WAIT_DONE: begin
        if (I2C_RBK_WE)
          rbk_d = sat_inc4(RBK_CNT);
        if (rdy_s) begin
          nack_d  = nack_s;
          state_d = S_FINISH;
        end else if (timer_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef I2C_RBK_CHECK_EN
    if (state_d == S_FINISH && state_q != S_FINISH && rd_q && rbk_d != nbytes_q)
      err_d = 1'b1;
`endif
  end

  // ---- state register and wait-phase timer
  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_d != state_q || !(state_q == S_EXEC || state_q == S_WAIT_DONE))
        timer_q <= '0;
      else
        timer_q <= timer_q + TMR_W'(1);
    end
  end

  // ---- registered outputs, asserted in the cycle the state is entered
  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      CMD_READY   <= 1'b1;
      DIN_READY   <= 1'b0;
      DEV_SEL     <= 1'b0;
      LOAD_N_BYTE <= 1'b0;
      LOAD_ADDR   <= 1'b0;
      WRT_ENA     <= 1'b0;
      WRT_ADDR    <= 4'd0;
      WRT_DATA    <= 8'd0;
      EXECUTE     <= 1'b0;
      DONE        <= 1'b0;
      NACK        <= 1'b0;
      TIMEOUT     <= 1'b0;
      ERR         <= 1'b0;
      RBK_CNT     <= 4'd0;
      BUSY        <= 1'b0;
    end else begin
      CMD_READY   <= (state_d == S_IDLE);
      DIN_READY   <= (state_d == S_LD_DATA);
      // Select stays up from the first load until the master finishes.
      DEV_SEL     <= (state_d inside {S_LD_NB, S_LD_ADR, S_LD_DATA, S_EXEC, S_WAIT_DONE});
      LOAD_N_BYTE <= (state_d == S_LD_NB);
      LOAD_ADDR   <= (state_d == S_LD_ADR);
      WRT_ENA     <= wrt_ena_d;
      WRT_ADDR    <= wrt_addr_d;
      WRT_DATA    <= wrt_data_d;
      // Level, not pulse: the 1 MHz master must be able to sample it.
      EXECUTE     <= (state_d == S_EXEC);
      DONE        <= (state_d == S_FINISH);
      NACK        <= nack_d;
      TIMEOUT     <= timeout_d;
      ERR         <= err_d;
      RBK_CNT     <= rbk_d;
      BUSY        <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_i2c_cmd_seq.sv
`timescale 1ns/100ps
module tb_i2c_cmd_seq;

  localparam int TO_CYC = 300;
  localparam int ST_TO  = 40;
`ifdef I2C_RBK_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int M_NORMAL  = 0;
  localparam int M_NOSTART = 1;
  localparam int M_HANG    = 2;

  logic       CLK40 = 1'b0;
  logic       RST_N = 1'b0;
  logic       CMD_VALID = 1'b0, CMD_RD = 1'b0;
  logic [3:0] CMD_NBYTES = 4'd0;
  logic [7:0] CMD_ADDR = 8'd0;
  logic       DIN_VALID = 1'b0;
  logic [7:0] DIN = 8'd0;
  logic       I2C_READY, I2C_RBK_WE, I2C_S_NACK;
  logic       CMD_READY, DIN_READY, DEV_SEL, LOAD_N_BYTE, LOAD_ADDR, WRT_ENA;
  logic [3:0] WRT_ADDR, RBK_CNT;
  logic [7:0] WRT_DATA;
  logic       EXECUTE, DONE, NACK, TIMEOUT, ERR, BUSY;

  always #12.5 CLK40 = ~CLK40;

  i2c_cmd_seq #(.TO_CYCLES(TO_CYC), .START_TO(ST_TO)) dut (
    .CLK40(CLK40), .RST_N(RST_N),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_RD(CMD_RD),
    .CMD_NBYTES(CMD_NBYTES), .CMD_ADDR(CMD_ADDR),
    .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY), .DIN(DIN),
    .I2C_READY(I2C_READY), .I2C_RBK_WE(I2C_RBK_WE), .I2C_S_NACK(I2C_S_NACK),
    .DEV_SEL(DEV_SEL), .LOAD_N_BYTE(LOAD_N_BYTE), .LOAD_ADDR(LOAD_ADDR),
    .WRT_ENA(WRT_ENA), .WRT_ADDR(WRT_ADDR), .WRT_DATA(WRT_DATA),
    .EXECUTE(EXECUTE), .DONE(DONE), .NACK(NACK), .TIMEOUT(TIMEOUT),
    .ERR(ERR), .RBK_CNT(RBK_CNT), .BUSY(BUSY)
  );

  typedef struct packed {
    logic [1:0] kind;   // 0 = LOAD_N_BYTE, 1 = LOAD_ADDR, 2 = WRT_ENA
    logic [3:0] idx;
    logic [7:0] data;
  } ev_t;

  typedef struct packed {
    logic       illegal;
    logic       nack;
    logic       to;
    logic [3:0] rbk;
    logic       err;
    logic       chk_exec;
  } res_t;

  ev_t  ev_q[$];
  res_t res_q[$];
  int   checks = 0;
  int   errors = 0;
  logic st_nack = 1'b0, st_to = 1'b0;
  int   m_mode = 0, m_pulses = 0, m_dly = 0;
  logic m_nack = 1'b0, m_in_wait = 1'b0;
  logic [7:0] pay [16];
  int   exec_len = 0;
  logic prev_exec = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT output with no expected entry in scoreboard", name);
  endtask

  // Behavioural model: what the host should observe for one command.
  task automatic issue_cmd(input logic rd, input int nb, input logic [7:0] addr,
                           input int mode, input int pulses, input logic nk);
    res_t r;
    ev_t  e;
    int   n;
    m_mode = mode; m_pulses = pulses; m_nack = nk; m_dly = $urandom_range(0, 25);
    r = '0;
    if (nb == 0) begin
      r.illegal = 1'b1; r.err = 1'b1; r.nack = st_nack; r.to = st_to;
    end else begin
      e.kind = 2'd0; e.idx = 4'd0; e.data = 8'(nb * 16 + (rd ? 8 : 0));
      ev_q.push_back(e);
      e.kind = 2'd1; e.data = addr;
      ev_q.push_back(e);
      if (!rd) begin
        for (int i = 0; i < nb; i++) begin
          e.kind = 2'd2; e.idx = 4'(i); e.data = pay[i];
          ev_q.push_back(e);
        end
      end
      if (mode == M_NOSTART) begin
        r.to = 1'b1; r.chk_exec = 1'b1;
      end else begin
        r.rbk  = 4'((pulses > 15) ? 15 : pulses);
        r.to   = (mode == M_HANG);
        r.nack = (mode == M_NORMAL) && nk;
      end
      r.err   = CHK && rd && (int'(r.rbk) != nb);
      st_nack = r.nack;
      st_to   = r.to;
    end
    res_q.push_back(r);

    n = 0;
    @(negedge CLK40);
    while (!CMD_READY && n < 100) begin @(negedge CLK40); n++; end
    chk1("cmd_ready_before_issue", CMD_READY, 1'b1);
    CMD_VALID = 1'b1; CMD_RD = rd; CMD_NBYTES = 4'(nb); CMD_ADDR = addr;
    @(posedge CLK40); #1;
    CMD_VALID = 1'b0;
    @(negedge CLK40);
    if (nb != 0 && !rd) begin
      for (int i = 0; i < nb; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge CLK40);
        DIN = pay[i]; DIN_VALID = 1'b1;
        n = 0;
        while (!DIN_READY && n < 50) begin @(negedge CLK40); n++; end
        if (n >= 50) begin
          chk1("din_ready_wait", DIN_READY, 1'b1);
          DIN_VALID = 1'b0;
          break;
        end
        @(posedge CLK40); #1;
        DIN_VALID = 1'b0;
        @(negedge CLK40);
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((res_q.size() != 0 || !CMD_READY) && n < 2000) begin @(negedge CLK40); n++; end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL wait_idle: transaction pending after %0d cycles, expected completion", n);
      res_q.delete();
      ev_q.delete();
    end
    repeat (12) @(negedge CLK40);
  endtask

  // I2C master model
  initial begin
    I2C_READY = 1'b1; I2C_RBK_WE = 1'b0; I2C_S_NACK = 1'b0;
    forever begin
      @(negedge CLK40);
      if (RST_N && EXECUTE) begin
        if (m_mode == M_NOSTART) begin
          while (EXECUTE && RST_N) @(negedge CLK40);
        end else begin
          repeat (m_dly) @(negedge CLK40);
          I2C_READY = 1'b0;
          repeat (5) @(negedge CLK40);
          for (int p = 0; p < m_pulses; p++) begin
            repeat ($urandom_range(1, 3)) @(negedge CLK40);
            I2C_RBK_WE = 1'b1;
            @(negedge CLK40);
            I2C_RBK_WE = 1'b0;
          end
          m_in_wait = 1'b1;
          if (m_mode == M_HANG) begin
            while (!DONE && RST_N) @(negedge CLK40);
          end else begin
            if (m_nack) I2C_S_NACK = 1'b1;
            repeat (4) @(negedge CLK40);
          end
          I2C_READY = 1'b1;
          m_in_wait = 1'b0;
          repeat (8) @(negedge CLK40);
          I2C_S_NACK = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a strobe or status pulse
  always @(negedge CLK40) begin
    ev_t  e;
    res_t r;
    if (RST_N) begin
      if (EXECUTE) exec_len = prev_exec ? exec_len + 1 : 1;
      prev_exec = EXECUTE;
      if (LOAD_N_BYTE || LOAD_ADDR || WRT_ENA) begin
        chkv("one_strobe", int'(LOAD_N_BYTE) + int'(LOAD_ADDR) + int'(WRT_ENA), 1);
        if (ev_q.size() == 0) begin
          flag_fail("unexpected_strobe");
        end else begin
          e = ev_q.pop_front();
          chkv("strobe_kind", LOAD_N_BYTE ? 0 : (LOAD_ADDR ? 1 : 2), int'(e.kind));
          chkv("wrt_data", int'(WRT_DATA), int'(e.data));
          if (e.kind == 2'd2) chkv("wrt_addr", int'(WRT_ADDR), int'(e.idx));
          chk1("dev_sel_strobe", DEV_SEL, 1'b1);
        end
      end
      if (DONE || ERR) begin
        if (res_q.size() == 0) begin
          flag_fail("unexpected_done_err");
        end else begin
          r = res_q.pop_front();
          chk1("done", DONE, !r.illegal);
          chk1("err", ERR, r.err);
          chk1("nack", NACK, r.nack);
          chk1("timeout", TIMEOUT, r.to);
          if (!r.illegal) begin
            chkv("rbk_cnt", int'(RBK_CNT), int'(r.rbk));
            chk1("dev_sel_done", DEV_SEL, 1'b0);
            chk1("busy_done", BUSY, 1'b1);
            chk1("execute_done", EXECUTE, 1'b0);
            chkv("events_drained", ev_q.size(), 0);
            if (r.chk_exec) chkv("execute_len", exec_len, ST_TO);
          end else begin
            chk1("cmd_ready_err", CMD_READY, 1'b1);
            chk1("busy_err", BUSY, 1'b0);
          end
        end
      end
    end else begin
      prev_exec = 1'b0;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic rd, nk;
    int   nb, mode, pulses, k, n;

    // reset state
    repeat (2) @(negedge CLK40);
    chk1("rst_cmd_ready", CMD_READY, 1'b1);
    chkv("rst_ctrl_bits", int'({BUSY, DONE, ERR, NACK, TIMEOUT, EXECUTE, DEV_SEL,
                                LOAD_N_BYTE, LOAD_ADDR, WRT_ENA, DIN_READY}), 0);
    chkv("rst_wrt_data", int'(WRT_DATA), 0);
    chkv("rst_wrt_addr", int'(WRT_ADDR), 0);
    chkv("rst_rbk_cnt", int'(RBK_CNT), 0);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK40);

    // write 3 bytes to 0x10
    pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
    issue_cmd(1'b0, 3, 8'h10, M_NORMAL, 0, 1'b0); wait_idle();
    // read 2, full readback, then short readback
    issue_cmd(1'b1, 2, 8'h22, M_NORMAL, 2, 1'b0); wait_idle();
    issue_cmd(1'b1, 2, 8'h23, M_NORMAL, 1, 1'b0); wait_idle();
    // illegal byte count
    issue_cmd(1'b0, 0, 8'h00, M_NORMAL, 0, 1'b0); wait_idle();
    // master never leaves READY, then a clean command clears TIMEOUT
    issue_cmd(1'b1, 1, 8'h31, M_NOSTART, 0, 1'b0); wait_idle();
    issue_cmd(1'b1, 4, 8'h32, M_NORMAL, 4, 1'b0); wait_idle();
    // slave NACK, sticky through an illegal command, cleared by the next one
    issue_cmd(1'b1, 3, 8'h40, M_NORMAL, 3, 1'b1); wait_idle();
    issue_cmd(1'b1, 0, 8'h41, M_NORMAL, 0, 1'b0); wait_idle();
    pay[0] = 8'h5A;
    issue_cmd(1'b0, 1, 8'h42, M_NORMAL, 0, 1'b0); wait_idle();
    // master hangs busy, readback saturation
    issue_cmd(1'b1, 2, 8'h50, M_HANG, 2, 1'b0); wait_idle();
    issue_cmd(1'b1, 15, 8'h60, M_NORMAL, 17, 1'b0); wait_idle();

    // randomized commands
    for (int t = 0; t < 30; t++) begin
      rd   = 1'($urandom_range(0, 1));
      nb   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 15);
      k    = $urandom_range(0, 9);
      mode = (k < 8) ? M_NORMAL : ((k == 8) ? M_NOSTART : M_HANG);
      pulses = 0;
      if (rd && mode != M_NOSTART)
        pulses = ($urandom_range(0, 3) != 0) ? nb : $urandom_range(0, 17);
      nk = (mode == M_NORMAL) && ($urandom_range(0, 4) == 0);
      for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
      issue_cmd(rd, nb, 8'($urandom), mode, pulses, nk);
      wait_idle();
    end

    // reset during WAIT_DONE
    issue_cmd(1'b1, 4, 8'h55, M_HANG, 2, 1'b0);
    n = 0;
    while (!m_in_wait && n < 500) begin @(negedge CLK40); n++; end
    repeat (10) @(negedge CLK40);
    chk1("pre_rst_dev_sel", DEV_SEL, 1'b1);
    chk1("pre_rst_busy", BUSY, 1'b1);
    @(posedge CLK40); #3;
    RST_N = 1'b0;
    #1;
    chk1("rst_mid_execute", EXECUTE, 1'b0);
    chk1("rst_mid_dev_sel", DEV_SEL, 1'b0);
    chk1("rst_mid_busy", BUSY, 1'b0);
    chk1("rst_mid_cmd_ready", CMD_READY, 1'b1);
    res_q.delete(); ev_q.delete();
    st_nack = 1'b0; st_to = 1'b0;
    repeat (3) @(negedge CLK40);
    RST_N = 1'b1;
    @(negedge CLK40);
    chk1("post_rst_cmd_ready", CMD_READY, 1'b1);
    chk1("post_rst_timeout", TIMEOUT, 1'b0);
    chkv("post_rst_rbk_cnt", int'(RBK_CNT), 0);
    repeat (5) @(negedge CLK40);
    issue_cmd(1'b1, 2, 8'h66, M_NORMAL, 2, 1'b0); wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_seq.md
Name: i2c_cmd_seq

Overview:
- Command sequencer directly upstream of the 1 MHz I2C master interface, in the CLK40 domain.
- Accepts one I2C transaction descriptor plus its write payload from the slow-control host.
- Drives the master's load/write/execute strobes, then waits for completion through the master's READY handshake.
- Counts readback bytes and reports done, slave-NACK, timeout and error status.

Parameters:
- TO_CYCLES, 2000000, CLK40 cycles allowed per wait phase (50 ms) before timeout.
- START_TO, 400, CLK40 cycles allowed for the master to leave READY after EXECUTE is raised (10 us, ten 1 MHz periods).

Ports:
- CLK40  in  1  40 MHz clock
- RST_N  in  1  asynchronous active-low reset
- CMD_VALID  in  1  descriptor valid
- CMD_READY  out  1  sequencer can accept a descriptor
- CMD_RD  in  1  1 = read transaction, 0 = write
- CMD_NBYTES  in  4  byte count, 1..15; 0 is illegal
- CMD_ADDR  in  8  device register address
- DIN_VALID  in  1  write payload byte valid
- DIN_READY  out  1  payload byte accepted this cycle
- DIN  in  8  payload byte
- I2C_READY  in  1  master idle flag, 1 MHz domain, asynchronous to CLK40
- I2C_RBK_WE  in  1  master readback strobe, one CLK40 cycle
- I2C_S_NACK  in  1  master slave-NACK flag, 1 MHz domain
- DEV_SEL  out  1  select to master
- LOAD_N_BYTE  out  1  byte-count load strobe
- LOAD_ADDR  out  1  address load strobe
- WRT_ENA  out  1  payload write strobe
- WRT_ADDR  out  4  payload index
- WRT_DATA  out  8  data bus to master
- EXECUTE  out  1  start request to master
- DONE  out  1  one-cycle completion pulse
- NACK  out  1  sticky slave NACK, cleared on next accepted command
- TIMEOUT  out  1  sticky timeout, cleared on next accepted command
- ERR  out  1  one-cycle illegal-command pulse
- RBK_CNT  out  4  readback bytes seen in the current transaction
- BUSY  out  1  state is not IDLE

Behaviour:
- Reset values: all outputs 0 except CMD_READY = 1; state IDLE.
- Synchronisers: I2C_READY and I2C_S_NACK each pass through a 2-flop synchroniser to give rdy_s and nack_s. I2C_RBK_WE is already CLK40-timed and is used directly.
- IDLE: CMD_READY = 1.
  - CMD_VALID && CMD_NBYTES == 0: ERR pulses for 1 cycle and the state stays IDLE.
  - Otherwise the descriptor is latched; NACK, TIMEOUT and RBK_CNT clear; go to LD_NB.
- LD_NB (1 cycle): DEV_SEL = 1, LOAD_N_BYTE = 1, WRT_DATA = {nbytes, rd, 3'b000}. Go to LD_ADR.
- LD_ADR (1 cycle): DEV_SEL = 1, LOAD_ADDR = 1, WRT_DATA = addr.
  - Write transaction: go to LD_DATA with index = 0.
  - Read transaction: go to EXEC.
- LD_DATA: DIN_READY = 1.
  - On each DIN_VALID: DEV_SEL = 1, WRT_ENA = 1, WRT_ADDR = index, WRT_DATA = DIN, index increments.
  - Go to EXEC after byte nbytes-1 is accepted.
  - A DIN_VALID stall has no time limit in this phase.
- EXEC: DEV_SEL = 1, EXECUTE = 1, held level (not pulsed) so the 1 MHz master samples it.
  - Exit to WAIT_DONE when rdy_s == 0.
  - If rdy_s is still 1 after START_TO cycles: TIMEOUT = 1, go to FINISH.
- WAIT_DONE: EXECUTE = 0, DEV_SEL = 1 (needed to keep the master's select valid).
  - Each I2C_RBK_WE increments RBK_CNT; saturates at 15.
  - On rdy_s == 1: NACK = nack_s, go to FINISH.
  - If rdy_s is still 0 after TO_CYCLES cycles: TIMEOUT = 1, go to FINISH.
- FINISH (1 cycle): DONE = 1, DEV_SEL = 0, go to IDLE.
- Timeout counter: width clog2(TO_CYCLES+1); clears on every state entry.
- Output timing: strobes are registered outputs, asserted in the cycle the state is entered.
- CMD_VALID while not IDLE: ignored, since CMD_READY = 0.
- Reset mid-operation: returns to IDLE at once. All strobes drop asynchronously; EXECUTE is never left high.

Optional Feature:
- Macro I2C_RBK_CHECK_EN.
- Defined: on a read transaction, if RBK_CNT != nbytes when FINISH is entered, ERR pulses together with DONE.
- Undefined: no count comparison; ERR fires only for NBYTES == 0. RBK_CNT is still reported.

Test Plan:
- Write: NBYTES = 3, ADDR = 0x10, payload 0xA1/0xB2/0xC3 → LOAD_N_BYTE with WRT_DATA = 0x30; LOAD_ADDR with 0x10; WRT_ENA at WRT_ADDR 0, 1, 2 with the matching bytes; EXECUTE until model READY falls; DONE after READY returns; NACK = 0, TIMEOUT = 0.
- Read: NBYTES = 2, RD = 1 → WRT_DATA = 0x28 on LOAD_N_BYTE; no WRT_ENA; model produces 2 RBK_WE pulses → RBK_CNT = 2, DONE = 1. With I2C_RBK_CHECK_EN and only 1 pulse, ERR pulses with DONE.
- NBYTES = 0 → ERR for 1 cycle, no strobes, CMD_READY stays 1.
- Model READY never falls → TIMEOUT = 1 after START_TO cycles, then DONE; next command clears TIMEOUT.
- Model asserts S_NACK before READY returns → NACK = 1 with DONE; stays 1 until the next command is accepted.
- RST_N low during WAIT_DONE → EXECUTE, DEV_SEL, BUSY drop immediately; CMD_READY = 1 after release.
